// File: rtl/phase_sequencer_pkg.sv
// phase_sequencer_pkg
//   Shared constants for the RockWave instruction phase sequencer:
//   named phase positions, default phase count, top-level state encoding.
package phase_sequencer_pkg;

  localparam int PH_FETCH     = 0;
  localparam int PH_DECODE    = 1;
  localparam int PH_EXECUTE   = 2;
  localparam int PH_MEMACCESS = 3;
  localparam int PH_WRITEBACK = 4;

  localparam int DEF_NUM_PHASE = 5;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/phase_sequencer_next_sel.sv
// phase_sequencer_next_sel
//   Purely combinational successor search for the one-hot phase vector.
//   Ports:
//     i_current  : one-hot active phase
//     i_skip     : per-phase bypass mask (bit 0 never matters, FETCH is below everything)
//     o_next     : one-hot of the lowest non-skipped phase above the current one,
//                  or FETCH when none exists
//     o_boundary : no later phase remains; the instruction ends on this advance
module phase_sequencer_next_sel
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASE = DEF_NUM_PHASE
) (
  input  logic [NUM_PHASE-1:0] i_current,
  input  logic [NUM_PHASE-1:0] i_skip,
  output logic [NUM_PHASE-1:0] o_next,
  output logic                 o_boundary
);

  logic [NUM_PHASE-1:0] w_above;
  logic                 w_seen;
  logic                 w_found;

  // w_above marks every bit strictly above the active phase.
  always_comb begin
    w_above = '0;
    w_seen  = 1'b0;
    for (int k = 0; k < NUM_PHASE; k++) begin
      w_above[k] = w_seen;
      w_seen     = w_seen | i_current[k];
    end
  end

  always_comb begin
    o_next  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_PHASE; k++) begin
      if (!w_found && w_above[k] && !i_skip[k]) begin
        o_next[k] = 1'b1;
        w_found   = 1'b1;
      end
    end
    o_boundary = !w_found;
    if (!w_found) o_next[PH_FETCH] = 1'b1;
  end

endmodule

// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Multi-cycle instruction phase sequencer with per-phase stall, phase
//   skipping, flush to FETCH, halt at instruction boundaries and
//   retire/stall counters. All outputs are registered.
//   Ports:
//     i_clk, i_rst_n : clock, async active-low reset
//     i_stall        : hold phase k while it is current
//     i_skip         : bypass phase k on the next advance
//     i_flush        : abandon instruction, return to FETCH (ignored in HALT)
//     i_halt_req     : park in HALT at the next boundary; release resumes
//     o_current      : one-hot active phase, zero while halted
//     o_phase_idx    : binary index of o_current, zero while halted
//     o_halted       : parked in HALT
//     o_retire       : one-cycle pulse after an instruction completes
//     o_retire_cnt   : completed instruction count (wraps)
//     o_stall_cnt    : stalled cycle count (wraps)
//
//   state   | meaning
//   ST_RUN  | walking phases, o_current one-hot
//   ST_HALT | parked between instructions, o_current zero
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NUM_PHASE = DEF_NUM_PHASE,
  parameter int CNT_W     = 32,
  parameter int PIDX_W    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PHASE-1:0] i_stall,
  input  logic [NUM_PHASE-1:0] i_skip,
  input  logic                 i_flush,
  input  logic                 i_halt_req,
  output logic [NUM_PHASE-1:0] o_current,
  output logic [PIDX_W-1:0]    o_phase_idx,
  output logic                 o_halted,
  output logic                 o_retire,
  output logic [CNT_W-1:0]     o_retire_cnt,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  localparam logic [NUM_PHASE-1:0] ONEHOT_FETCH = NUM_PHASE'(1) << PH_FETCH;

  seq_state_t           r_state;
  logic [NUM_PHASE-1:0] r_current;
  logic [PIDX_W-1:0]    r_phase_idx;
  logic                 r_retire;
  logic [CNT_W-1:0]     r_retire_cnt;
  logic [CNT_W-1:0]     r_stall_cnt;

  seq_state_t           w_state_nxt;
  logic [NUM_PHASE-1:0] w_cur_nxt;
  logic [PIDX_W-1:0]    w_idx_nxt;
  logic                 w_retire_nxt;
  logic                 w_stall_inc;
  logic [NUM_PHASE-1:0] w_adv;
  logic                 w_boundary;
  logic                 w_stalled;

  phase_sequencer_next_sel #(.NUM_PHASE(NUM_PHASE)) u_next_sel (
    .i_current  (r_current),
    .i_skip     (i_skip),
    .o_next     (w_adv),
    .o_boundary (w_boundary)
  );

  assign w_stalled = |(i_stall & r_current);

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_current;
    w_retire_nxt = 1'b0;
    w_stall_inc  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (i_flush) begin
          w_cur_nxt = ONEHOT_FETCH;
        end else if (w_stalled) begin
          w_stall_inc = 1'b1;
        end else if (w_boundary) begin
          w_retire_nxt = 1'b1;
          if (i_halt_req) begin
            w_state_nxt = ST_HALT;
            w_cur_nxt   = '0;
          end else begin
            w_cur_nxt = ONEHOT_FETCH;
          end
        end else begin
          w_cur_nxt = w_adv;
        end
      end
      ST_HALT: begin
        if (!i_halt_req) begin
          w_state_nxt = ST_RUN;
          w_cur_nxt   = ONEHOT_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cur_nxt   = ONEHOT_FETCH;
      end
    endcase
  end

  // Index is encoded from the next one-hot so it is registered alongside it.
  always_comb begin
    w_idx_nxt = '0;
    for (int k = 0; k < NUM_PHASE; k++) begin
      if (w_cur_nxt[k]) w_idx_nxt = PIDX_W'(k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_RUN;
      r_current    <= ONEHOT_FETCH;
      r_phase_idx  <= '0;
      r_retire     <= 1'b0;
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_current   <= w_cur_nxt;
      r_phase_idx <= w_idx_nxt;
      r_retire    <= w_retire_nxt;
      if (w_retire_nxt) r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      if (w_stall_inc)  r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_current    = r_current;
  assign o_phase_idx  = r_phase_idx;
  assign o_halted     = (r_state == ST_HALT);
  assign o_retire     = r_retire;
  assign o_retire_cnt = r_retire_cnt;
  assign o_stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] stall, skip;
  logic         flush, halt_req;
  logic [N-1:0] current;
  logic [3:0]   phase_idx;
  logic         halted, retire;
  logic [31:0]  retire_cnt, stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: integer phase number plus halt flag.
  int          m_phase;
  bit          m_halted;
  bit          m_retire;
  logic [31:0] m_rc, m_sc;

  logic [31:0] save_rc, save_sc;
  int          retire_seen;

  phase_sequencer #(.NUM_PHASE(N), .CNT_W(32), .PIDX_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_skip       (skip),
    .i_flush      (flush),
    .i_halt_req   (halt_req),
    .o_current    (current),
    .o_phase_idx  (phase_idx),
    .o_halted     (halted),
    .o_retire     (retire),
    .o_retire_cnt (retire_cnt),
    .o_stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_halted = 0;
    m_retire = 0;
    m_rc     = 0;
    m_sc     = 0;
  endtask

  task automatic model_step(input logic [N-1:0] st, input logic [N-1:0] sk,
                            input logic fl, input logic hr);
    int nxt;
    m_retire = 0;
    if (m_halted) begin
      if (!hr) begin
        m_halted = 0;
        m_phase  = 0;
      end
    end else if (fl) begin
      m_phase = 0;
    end else if (st[m_phase]) begin
      m_sc = m_sc + 1;
    end else begin
      nxt = -1;
      for (int k = N - 1; k > m_phase; k--) if (!sk[k]) nxt = k;
      if (nxt >= 0) begin
        m_phase = nxt;
      end else begin
        m_retire = 1;
        m_rc     = m_rc + 1;
        if (hr) m_halted = 1;
        m_phase = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] e_cur;
    logic [3:0]   e_idx;
    e_cur = m_halted ? '0 : N'(1 << m_phase);
    e_idx = m_halted ? 4'd0 : 4'(m_phase);
    chk({tag, ".current"},    current,    e_cur);
    chk({tag, ".phase_idx"},  phase_idx,  e_idx);
    chk({tag, ".halted"},     halted,     m_halted);
    chk({tag, ".retire"},     retire,     m_retire);
    chk({tag, ".retire_cnt"}, retire_cnt, m_rc);
    chk({tag, ".stall_cnt"},  stall_cnt,  m_sc);
  endtask

  // Called at a negedge: drive, predict, wait one cycle, compare.
  task automatic step(input string tag, input logic [N-1:0] st, input logic [N-1:0] sk,
                      input logic fl, input logic hr);
    stall = st; skip = sk; flush = fl; halt_req = hr;
    model_step(st, sk, fl, hr);
    @(negedge clk);
    check_all(tag);
    if (retire === 1'b1) retire_seen++;
  endtask

  task automatic to_fetch();
    for (int i = 0; i < 20 && !(m_phase == 0 && !m_halted); i++) step("to_fetch", 0, 0, 0, 0);
  endtask

  initial begin
    logic [N-1:0] r_st, r_sk;
    logic         r_fl;
    logic         r_hr;

    rst_n = 1'b0; stall = '0; skip = '0; flush = 1'b0; halt_req = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Free run: 1,2,4,8,16,1,... with retire at cycles 5 and 10 after release.
    retire_seen = 0;
    for (int i = 0; i < 12; i++) step("free_run", 0, 0, 0, 0);
    chk("free_run.retire_pulses", 32'(retire_seen), 32'd2);
    chk("free_run.retire_cnt", retire_cnt, 32'd2);
    chk("free_run.end_phase", current, 5'b00100);
    to_fetch();

    // Each phase stalled two cycles.
    save_rc = m_rc; save_sc = m_sc;
    for (int k = 0; k < N; k++) begin
      step("stall_each", N'(1 << k), 0, 0, 0);
      step("stall_each", N'(1 << k), 0, 0, 0);
      step("stall_each", 0, 0, 0, 0);
    end
    chk("stall_each.stall_delta", stall_cnt - save_sc, 32'd10);
    chk("stall_each.retire_delta", retire_cnt - save_rc, 32'd1);
    chk("stall_each.at_fetch", current, 5'b00001);

    // Skip MEMACCESS: 1,2,4,16,1 in 4 cycles.
    save_rc = m_rc; retire_seen = 0;
    step("skip", 0, 5'b01000, 0, 0);
    step("skip", 0, 5'b01000, 0, 0);
    step("skip", 0, 5'b01000, 0, 0);
    chk("skip.writeback", current, 5'b10000);
    step("skip", 0, 5'b01000, 0, 0);
    chk("skip.back_to_fetch", current, 5'b00001);
    chk("skip.retire_once", 32'(retire_seen), 32'd1);

    // Flush during a stalled EXECUTE.
    step("pre_flush", 0, 0, 0, 0);
    step("pre_flush", 0, 0, 0, 0);
    save_rc = m_rc; save_sc = m_sc;
    step("flush", 5'b00100, 0, 1, 0);
    chk("flush.current", current, 5'b00001);
    chk("flush.no_retire", retire, 1'b0);
    chk("flush.retire_cnt", retire_cnt, save_rc);
    chk("flush.stall_cnt", stall_cnt, save_sc);

    // Halt requested during DECODE, honoured at the boundary.
    step("halt", 0, 0, 0, 0);
    retire_seen = 0;
    for (int i = 0; i < 4; i++) step("halt_run", 0, 0, 0, 1);
    chk("halt.halted", halted, 1'b1);
    chk("halt.current_zero", current, 5'b00000);
    for (int i = 0; i < 5; i++)
      step("halt_hold", N'($urandom), N'($urandom), 1'($urandom), 1);
    chk("halt.single_retire", 32'(retire_seen), 32'd1);
    step("resume", 0, 0, 0, 0);
    chk("resume.current", current, 5'b00001);

    // Asynchronous reset in the middle of MEMACCESS.
    for (int i = 0; i < 3; i++) step("pre_reset", 0, 0, 0, 0);
    chk("pre_reset.memaccess", current, 5'b01000);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_reset.current", current, 5'b00001);
    chk("async_reset.retire_cnt", retire_cnt, 32'd0);
    chk("async_reset.stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("post_reset", 0, 0, 0, 0);

    // Randomised traffic against the model.
    r_hr = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r_st = N'($urandom & $urandom);
      r_sk = N'($urandom);
      r_fl = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) r_hr = ~r_hr;
      step("random", r_st, r_sk, r_fl, r_hr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
